// File: rtl/fetch_redirect.sv
// Fetch-stage PC, imem req/ready handshake with skid buffer, and IF/ID register.
// A flush redirects the PC to the MEM-stage target and squashes anything still on the old path.
module fetch_redirect #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             stall,
    input  logic [1:0]       mem_jump,
    input  logic [31:0]      mem_PC_BRANCH,
    input  logic [31:0]      mem_jalr_out,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic             if_id_valid,
    output logic [31:0]      if_id_pc,
    output logic [31:0]      if_id_instr,
    output logic [CNT_W-1:0] flush_count
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {S_BOOT, S_FETCH, S_WAIT, S_HOLD, S_DRAIN} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] drain_addr;
    logic [31:0] skid_data;
    logic [31:0] target;

    always_comb begin
        target    = (mem_jump == 2'b11) ? (mem_jalr_out & ~32'd1) : mem_PC_BRANCH;
        imem_req  = 1'b0;
        imem_addr = pc;
        case (state)
            S_FETCH: imem_req = !stall;
            S_WAIT:  imem_req = 1'b1;
            S_DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = drain_addr;
            end
            default: imem_req = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_BOOT;
            pc          <= RESET_PC;
            drain_addr  <= RESET_PC;
            skid_data   <= NOP;
            if_id_valid <= 1'b0;
            if_id_pc    <= '0;
            if_id_instr <= NOP;
            flush_count <= '0;
        end else begin
            if (flush && flush_count != '1)
                flush_count <= flush_count + CNT_W'(1);

            // Every flush branch squashes IF/ID so nothing from the old path survives.
            if (flush && state != S_BOOT) begin
                if_id_valid <= 1'b0;
                if_id_instr <= NOP;
            end

            case (state)
                S_BOOT: begin
                    if (flush) pc <= target;
                    state <= S_FETCH;
                end
                S_FETCH: begin
                    if (flush) begin
                        pc <= target;
                        if (imem_req && !imem_ready) begin
                            drain_addr <= pc;
                            state      <= S_DRAIN;
                        end
                    end else if (imem_req && imem_ready) begin
                        if_id_valid <= 1'b1;
                        if_id_pc    <= pc;
                        if_id_instr <= imem_rdata;
                        pc          <= pc + 32'd4;
                    end else if (imem_req) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        pc <= target;
                        if (imem_ready) state <= S_FETCH;
                        else begin
                            drain_addr <= pc;
                            state      <= S_DRAIN;
                        end
                    end else if (imem_ready && !stall) begin
                        if_id_valid <= 1'b1;
                        if_id_pc    <= pc;
                        if_id_instr <= imem_rdata;
                        pc          <= pc + 32'd4;
                        state       <= S_FETCH;
                    end else if (imem_ready) begin
                        skid_data <= imem_rdata;
                        state     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (flush) begin
                        pc    <= target;
                        state <= S_FETCH;
                    end else if (!stall) begin
                        if_id_valid <= 1'b1;
                        if_id_pc    <= pc;
                        if_id_instr <= skid_data;
                        pc          <= pc + 32'd4;
                        state       <= S_FETCH;
                    end
                end
                S_DRAIN: begin
                    // Old-path request must complete at its original address; its data is dropped.
                    if (flush) pc <= target;
                    if (imem_ready) state <= S_FETCH;
                end
                default: state <= S_BOOT;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_redirect.sv
// Directed bench for fetch_redirect: sequential fetch, branch/jalr flush, drain,
// stall skid, async reset mid-request and flush counter saturation.
module tb_fetch_redirect;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush, stall;
    logic [1:0]  mem_jump;
    logic [31:0] mem_PC_BRANCH, mem_jalr_out;
    logic        imem_req, imem_ready;
    logic [31:0] imem_addr, imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_pc, if_id_instr;
    logic [15:0] flush_count;

    int errors = 0;
    int checks = 0;

    // Instruction memory returns a tag derived from the address.
    assign imem_rdata = 32'hC000_0000 | imem_addr;

    fetch_redirect #(.RESET_PC(32'h0), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .stall(stall),
        .mem_jump(mem_jump), .mem_PC_BRANCH(mem_PC_BRANCH), .mem_jalr_out(mem_jalr_out),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
        .if_id_instr(if_id_instr), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; stall = 1'b0; mem_jump = 2'b00;
        mem_PC_BRANCH = '0; mem_jalr_out = '0; imem_ready = 1'b1;
        tick(); tick();
        chk("rst_valid", 32'(if_id_valid), 32'd0);
        chk("rst_req",   32'(imem_req),    32'd0);
        chk("rst_instr", if_id_instr,      32'h0000_0013);
        chk("rst_pc",    if_id_pc,         32'd0);
        chk("rst_cnt",   32'(flush_count), 32'd0);
        reset_n = 1'b1;

        // 1: sequential fetch
        tick();
        chk("boot_req",   32'(imem_req),    32'd1);
        chk("boot_valid", 32'(if_id_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("seq_valid", 32'(if_id_valid), 32'd1);
            chk("seq_pc",    if_id_pc,         32'(4 * i));
            chk("seq_instr", if_id_instr,      32'hC000_0000 | 32'(4 * i));
        end

        // 2: branch flush
        flush = 1'b1; mem_jump = 2'b00; mem_PC_BRANCH = 32'h100;
        tick();
        flush = 1'b0;
        chk("br_valid", 32'(if_id_valid), 32'd0);
        chk("br_addr",  imem_addr,        32'h100);
        chk("br_cnt",   32'(flush_count), 32'd1);
        tick();
        chk("br_tgt_pc",    if_id_pc,    32'h100);
        chk("br_tgt_instr", if_id_instr, 32'hC000_0100);

        // 3: jalr flush clears bit 0
        flush = 1'b1; mem_jump = 2'b11; mem_jalr_out = 32'h203;
        tick();
        flush = 1'b0; mem_jump = 2'b00;
        chk("jalr_addr",  imem_addr,        32'h202);
        chk("jalr_cnt",   32'(flush_count), 32'd2);
        chk("jalr_valid", 32'(if_id_valid), 32'd0);
        tick();
        chk("jalr_tgt_pc", if_id_pc, 32'h202);

        // 4: flush during an outstanding request -> drain
        imem_ready = 1'b0;
        tick();
        chk("wait_req",  32'(imem_req), 32'd1);
        chk("wait_addr", imem_addr,     32'h206);
        flush = 1'b1; mem_PC_BRANCH = 32'h300;
        tick();
        flush = 1'b0;
        chk("drain_req",   32'(imem_req),    32'd1);
        chk("drain_addr",  imem_addr,        32'h206);
        chk("drain_valid", 32'(if_id_valid), 32'd0);
        tick();
        chk("drain_hold", imem_addr, 32'h206);
        imem_ready = 1'b1;
        tick();
        chk("drain_drop", 32'(if_id_valid), 32'd0);
        chk("drain_next", imem_addr,        32'h300);
        tick();
        chk("drain_tgt_pc", if_id_pc,         32'h300);
        chk("drain_tgt_v",  32'(if_id_valid), 32'd1);
        chk("drain_cnt",    32'(flush_count), 32'd3);

        // 5: response arrives while ID stalls -> skid buffer
        imem_ready = 1'b0;
        tick();
        stall = 1'b1; imem_ready = 1'b1;
        tick();
        chk("hold_req", 32'(imem_req), 32'd0);
        chk("hold_pc",  if_id_pc,      32'h300);
        tick();
        chk("hold_req2", 32'(imem_req), 32'd0);
        chk("hold_pc2",  if_id_pc,      32'h300);
        stall = 1'b0;
        tick();
        chk("skid_pc",    if_id_pc,    32'h304);
        chk("skid_instr", if_id_instr, 32'hC000_0304);
        chk("skid_addr",  imem_addr,   32'h308);

        // 6: async reset mid-WAIT
        imem_ready = 1'b0;
        tick();
        chk("w6_addr", imem_addr, 32'h308);
        reset_n = 1'b0;
        #1;
        chk("arst_req",   32'(imem_req),    32'd0);
        chk("arst_addr",  imem_addr,        32'd0);
        chk("arst_valid", 32'(if_id_valid), 32'd0);
        chk("arst_cnt",   32'(flush_count), 32'd0);
        chk("arst_instr", if_id_instr,      32'h0000_0013);
        imem_ready = 1'b1;
        tick();
        reset_n = 1'b1;
        tick(); tick();
        chk("restart_pc", if_id_pc,         32'd0);
        chk("restart_v",  32'(if_id_valid), 32'd1);

        // Flush counter saturation: 2^16+3 flush cycles
        flush = 1'b1; mem_PC_BRANCH = 32'h0;
        for (int i = 0; i < 65534; i++) tick();
        chk("cnt_near", 32'(flush_count), 32'hFFFE);
        for (int i = 0; i < 5; i++) tick();
        chk("cnt_sat", 32'(flush_count), 32'hFFFF);
        flush = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
